// File: rtl/cpu_pkg.sv
// Shared RV32I decode constants for the ID stage: opcode values, immediate formats, default XLEN.
package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file: two async reads, one sync write, x0 and out-of-range addresses read as zero.
// Optional ID_BYPASS_EN: a read of the address being written this cycle returns the incoming write data.
module regfile_bypass #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2
);

  localparam int IDX_W = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic in_range(input logic [REG_AW-1:0] a);
    return (a >> IDX_W) == '0;
  endfunction

  function automatic logic readable(input logic [REG_AW-1:0] a);
    return (a != '0) && in_range(a);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && readable(waddr)) begin
      regs[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (readable(raddr1)) rdata1 = regs[raddr1[IDX_W-1:0]];
`ifdef ID_BYPASS_EN
    if (we && (waddr == raddr1) && readable(raddr1)) rdata1 = wdata;
`endif
  end

  always_comb begin
    rdata2 = '0;
    if (readable(raddr2)) rdata2 = regs[raddr2[IDX_W-1:0]];
`ifdef ID_BYPASS_EN
    if (we && (waddr == raddr2) && readable(raddr2)) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/id_pipe_stage.sv
// RV32I instruction-decode stage: decode, immediate generation, load-use stall, flush, registered ID->EX bundle.
// Build option ID_BYPASS_EN enables register-file write-through on same-cycle read/write.
module id_pipe_stage
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [6:0]        id_opcode,
  output logic [2:0]        id_funct3,
  output logic [6:0]        id_funct7,
  output logic [REG_AW-1:0] id_rs1_addr,
  output logic [REG_AW-1:0] id_rs2_addr,
  output logic [REG_AW-1:0] id_rd_addr,
  output logic [XLEN-1:0]   id_rs1_data,
  output logic [XLEN-1:0]   id_rs2_data,
  output logic [XLEN-1:0]   id_imm
);

  function automatic imm_type_e imm_sel(input logic [6:0] opc);
    case (opc)
      OP_IMM, LOAD, JALR: return IMM_I;
      STORE:              return IMM_S;
      BRANCH:             return IMM_B;
      LUI, AUIPC:         return IMM_U;
      JAL:                return IMM_J;
      default:            return IMM_NONE;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input imm_type_e t);
    logic signed [31:0] imm32;
    case (t)
      IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm32 = {ins[31:12], 12'b0};
      IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return XLEN'(imm32);
  endfunction

  // Stage p0: combinational decode of the IF instruction and register reads
  logic [6:0]        opcode_p0;
  logic [REG_AW-1:0] rs1_p0, rs2_p0, rd_p0;
  logic              use_rs1_p0, use_rs2_p0;
  logic              hazard_p0, advance_p0, accept_p0;
  logic [XLEN-1:0]   rs1_data_p0, rs2_data_p0, imm_p0;

  assign opcode_p0  = if_instr[6:0];
  assign rs1_p0     = REG_AW'(if_instr[19:15]);
  assign rs2_p0     = REG_AW'(if_instr[24:20]);
  assign rd_p0      = REG_AW'(if_instr[11:7]);
  assign use_rs1_p0 = !(opcode_p0 inside {LUI, AUIPC, JAL});
  assign use_rs2_p0 = opcode_p0 inside {OP, STORE, BRANCH};
  assign imm_p0     = gen_imm(if_instr, imm_sel(opcode_p0));

  // A load in EX cannot forward in time, so a dependent instruction waits in IF
  assign hazard_p0  = if_valid && ex_is_load && (ex_rd_addr != '0) &&
                      ((use_rs1_p0 && (rs1_p0 == ex_rd_addr)) ||
                       (use_rs2_p0 && (rs2_p0 == ex_rd_addr)));
  assign advance_p0 = !id_valid || ex_ready;
  assign accept_p0  = if_valid && !hazard_p0;

  // During flush the incoming word is consumed and dropped so IF can redirect
  assign if_ready   = !rst && (flush || (advance_p0 && !hazard_p0));

  regfile_bypass #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1_p0),
    .rdata1 (rs1_data_p0),
    .raddr2 (rs2_p0),
    .rdata2 (rs2_data_p0)
  );

  // Stage p1: registered ID->EX bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_opcode   <= '0;
      id_funct3   <= '0;
      id_funct7   <= '0;
      id_rs1_addr <= '0;
      id_rs2_addr <= '0;
      id_rd_addr  <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (advance_p0) begin
      id_valid <= accept_p0;
      if (accept_p0) begin
        id_pc       <= if_pc;
        id_opcode   <= opcode_p0;
        id_funct3   <= if_instr[14:12];
        id_funct7   <= if_instr[31:25];
        id_rs1_addr <= rs1_p0;
        id_rs2_addr <= rs2_p0;
        id_rd_addr  <= rd_p0;
        id_rs1_data <= rs1_data_p0;
        id_rs2_data <= rs2_data_p0;
        id_imm      <= imm_p0;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios plus a randomized scoreboard run.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_is_load;
  logic [4:0]  ex_rd_addr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid;
  logic        ex_ready;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];

  id_pipe_stage dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .flush       (flush),
    .ex_is_load  (ex_is_load),
    .ex_rd_addr  (ex_rd_addr),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .id_valid    (id_valid),
    .ex_ready    (ex_ready),
    .id_pc       (id_pc),
    .id_opcode   (id_opcode),
    .id_funct3   (id_funct3),
    .id_funct7   (id_funct7),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rd_addr  (id_rd_addr),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .id_imm      (id_imm)
  );

  always #5 clk = ~clk;

  // Reference register file
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 32'h0;
    end else if (wb_we && wb_addr != 5'd0) begin
      mregs[wb_addr] <= wb_data;
    end
  end

  function automatic logic [31:0] ref_read(input int a);
    if (a == 0) return 32'h0;
`ifdef ID_BYPASS_EN
    if (wb_we && int'(wb_addr) == a) return wb_data;
`endif
    return mregs[a];
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int unsigned u;
    int unsigned op;
    int v;
    u  = ins;
    op = u % 128;
    v  = 0;
    if (op == 19 || op == 3 || op == 103) begin
      v = int'(u >> 20);
      if (v >= 2048) v -= 4096;
    end else if (op == 35) begin
      v = int'(((u >> 25) * 32) + ((u >> 7) % 32));
      if (v >= 2048) v -= 4096;
    end else if (op == 99) begin
      v = int'(((u >> 31) * 4096) + (((u >> 7) % 2) * 2048) +
               (((u >> 25) % 64) * 32) + (((u >> 8) % 16) * 2));
      if (v >= 4096) v -= 8192;
    end else if (op == 55 || op == 23) begin
      v = int'((u / 4096) * 4096);
    end else if (op == 111) begin
      v = int'(((u >> 31) * 1048576) + (((u >> 12) % 256) * 4096) +
               (((u >> 20) % 2) * 2048) + (((u >> 21) % 1024) * 2));
      if (v >= 1048576) v -= 2097152;
    end
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid   = 1'b0;
    if_instr   = 32'h0;
    if_pc      = 32'h0;
    flush      = 1'b0;
    ex_is_load = 1'b0;
    ex_rd_addr = 5'd0;
    wb_we      = 1'b0;
    wb_addr    = 5'd0;
    wb_data    = 32'h0;
    ex_ready   = 1'b1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    present(32'hFFB00093, 32'h0000_0040);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hCAFE_F00D;
    cyc();
    cyc();
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %b want 0", if_ready); end
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
    checks++;
    if ({id_pc, id_imm, id_rd_addr, id_rs1_data} !== '0) begin
      errors++; $display("FAIL reset_bundle got %h/%h/%h/%h want zeros", id_pc, id_imm, id_rd_addr, id_rs1_data);
    end
    rst = 1'b0;
    idle();
    cyc();
  endtask

  task automatic test_addi();
    present(32'hFFB00093, 32'h0000_0100);
    #1;
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL addi_if_ready got %b want 1", if_ready); end
    cyc();
    idle();
    checks++;
    if (id_valid !== 1'b1 || id_rd_addr !== 5'd1 || id_imm !== 32'hFFFF_FFFB ||
        id_rs1_data !== 32'h0 || id_pc !== 32'h100 || id_opcode !== 7'h13) begin
      errors++;
      $display("FAIL addi_bundle got v=%b rd=%0d imm=%h rs1=%h pc=%h op=%h want v=1 rd=1 imm=fffffffb rs1=0 pc=100 op=13",
               id_valid, id_rd_addr, id_imm, id_rs1_data, id_pc, id_opcode);
    end
    cyc();
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL addi_bubble got %b want 0", id_valid); end
  endtask

  task automatic test_regfile();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    cyc();
    wb_we = 1'b0;
    present(32'h0052_8333, 32'h0000_0110);
    cyc();
    checks++;
    if (id_rs1_data !== 32'h1234 || id_rs2_data !== 32'h1234) begin
      errors++; $display("FAIL rf_add_x5x5 got %h/%h want 00001234/00001234", id_rs1_data, id_rs2_data);
    end
    present(32'h0032_8333, 32'h0000_0114);
    cyc();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h114 || id_rs1_data !== 32'h1234 || id_rs2_data !== 32'h0) begin
      errors++; $display("FAIL rf_reset_cleared got v=%b pc=%h %h/%h want v=1 pc=114 00001234/0",
                         id_valid, id_pc, id_rs1_data, id_rs2_data);
    end
    idle();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    cyc();
    wb_we = 1'b0;
    present(32'h0000_0333, 32'h0000_0118);
    cyc();
    idle();
    checks++;
    if (id_valid !== 1'b1 || id_rs1_data !== 32'h0 || id_rs2_data !== 32'h0) begin
      errors++; $display("FAIL rf_x0 got v=%b %h/%h want v=1 0/0", id_valid, id_rs1_data, id_rs2_data);
    end
    cyc();
  endtask

  task automatic test_hazard();
    ex_is_load = 1'b1; ex_rd_addr = 5'd5;
    present(32'h0002_8333, 32'h0000_0120);
    #1;
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall got %b want 0", if_ready); end
    cyc();
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble got %b want 0", id_valid); end
    ex_is_load = 1'b0;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL hazard_release got %b want 1", if_ready); end
    cyc();
    idle();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h120 || id_rs1_addr !== 5'd5 || id_rd_addr !== 5'd6) begin
      errors++; $display("FAIL hazard_accept got v=%b pc=%h rs1=%0d rd=%0d want v=1 pc=120 rs1=5 rd=6",
                         id_valid, id_pc, id_rs1_addr, id_rd_addr);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    present(32'h0070_0113, 32'h0000_0200);
    cyc();
    ex_ready = 1'b0;
    present(32'h0090_0193, 32'h0000_0204);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_if_ready[%0d] got %b want 0", i, if_ready); end
      cyc();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_imm !== 32'h7 || id_rd_addr !== 5'd2) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b pc=%h imm=%h rd=%0d want v=1 pc=200 imm=7 rd=2",
                           i, id_valid, id_pc, id_imm, id_rd_addr);
      end
    end
    ex_ready = 1'b1;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got %b want 1", if_ready); end
    cyc();
    idle();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h204 || id_imm !== 32'h9 || id_rd_addr !== 5'd3) begin
      errors++; $display("FAIL bp_next got v=%b pc=%h imm=%h rd=%0d want v=1 pc=204 imm=9 rd=3",
                         id_valid, id_pc, id_imm, id_rd_addr);
    end
    cyc();
    checks++;
    if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b want 0", id_valid); end
  endtask

  task automatic test_flush();
    present(32'h0070_0113, 32'h0000_0300);
    cyc();
    present(32'h0090_0193, 32'h0000_0304);
    flush = 1'b1;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_if_ready got %b want 1", if_ready); end
    cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (id_valid !== 1'b0 || id_pc === 32'h304) begin
        errors++; $display("FAIL flush_kill[%0d] got v=%b pc=%h want v=0 pc!=304", i, id_valid, id_pc);
      end
      cyc();
    end
  endtask

  task automatic test_bypass_bimm();
    logic [31:0] exp;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1111;
    cyc();
    wb_data = 32'h0000_ABCD;
    present(32'h0003_8433, 32'h0000_0400);
`ifdef ID_BYPASS_EN
    exp = 32'h0000_ABCD;
`else
    exp = 32'h0000_1111;
`endif
    cyc();
    wb_we = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || id_rs1_data !== exp) begin
      errors++; $display("FAIL bypass_read got v=%b %h want v=1 %h", id_valid, id_rs1_data, exp);
    end
    present(32'h8000_0F63, 32'h0000_0404);
    cyc();
    idle();
    checks++;
    if (id_imm !== 32'hFFFF_F01E || id_opcode !== 7'h63) begin
      errors++; $display("FAIL b_imm got %h op=%h want fffff01e op=63", id_imm, id_opcode);
    end
    cyc();
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
  } bundle_t;

  task automatic test_random(input int n);
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    bundle_t    held;
    logic       m_valid, pending, took, exp_ready, hz, u1, u2;
    int unsigned u, op, r1, r2;
    logic [160:0] act, want;
    m_valid = 1'b0;
    pending = 1'b0;
    held    = '{default: 32'h0};
    for (int i = 0; i < n; i++) begin
      if (!pending) begin
        if_valid = ($urandom_range(9, 0) < 7);
        if_instr = ($urandom & 32'hFFFF_FF80) | 32'(ops[$urandom_range(9, 0)]);
        if_pc    = $urandom & 32'hFFFF_FFFC;
      end
      ex_ready   = ($urandom_range(3, 0) != 0);
      ex_is_load = ($urandom_range(2, 0) == 0);
      ex_rd_addr = 5'($urandom_range(31, 0));
      wb_we      = $urandom_range(1, 0) == 1;
      wb_addr    = 5'($urandom_range(31, 0));
      wb_data    = $urandom;
      #1;
      u  = if_instr;
      op = u % 128;
      r1 = (u >> 15) % 32;
      r2 = (u >> 20) % 32;
      u1 = !(op == 55 || op == 23 || op == 111);
      u2 = (op == 51 || op == 35 || op == 99);
      hz = if_valid && ex_is_load && ex_rd_addr != 0 &&
           ((u1 && r1 == int'(ex_rd_addr)) || (u2 && r2 == int'(ex_rd_addr)));
      exp_ready = (!m_valid || ex_ready) && !hz;
      checks++;
      if (if_ready !== exp_ready) begin
        errors++; $display("FAIL rand_if_ready[%0d] got %b want %b", i, if_ready, exp_ready);
      end
      checks++;
      if (id_valid !== m_valid) begin
        errors++; $display("FAIL rand_id_valid[%0d] got %b want %b", i, id_valid, m_valid);
      end
      if (m_valid) begin
        act  = {id_pc, id_opcode, id_funct3, id_funct7, id_rs1_addr, id_rs2_addr, id_rd_addr,
                id_rs1_data, id_rs2_data, id_imm};
        want = {held.pc, 7'(held.instr % 128), 3'((held.instr >> 12) % 8), 7'(held.instr >> 25),
                5'((held.instr >> 15) % 32), 5'((held.instr >> 20) % 32), 5'((held.instr >> 7) % 32),
                held.rs1d, held.rs2d, held.imm};
        checks++;
        if (act !== want) begin
          errors++; $display("FAIL rand_bundle[%0d] got %h want %h", i, act, want);
        end
      end
      took = if_valid && exp_ready;
      if (took) begin
        held.pc    = if_pc;
        held.instr = if_instr;
        held.rs1d  = ref_read(int'(r1));
        held.rs2d  = ref_read(int'(r2));
        held.imm   = ref_imm(if_instr);
        m_valid    = 1'b1;
      end else if (!m_valid || ex_ready) begin
        m_valid = 1'b0;
      end
      pending = if_valid && !took;
      cyc();
    end
    idle();
    cyc();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_addi();
    test_regfile();
    test_hazard();
    test_backpressure();
    test_flush();
    test_bypass_bimm();
    test_random(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
